// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and fetch FSM state encoding
package pipe_pkg;
   localparam logic [15:0] NOP_INSTR  = 16'h0800;
   localparam logic [15:0] HALT_INSTR = 16'h0000;
   localparam logic [15:0] RESET_PC   = 16'h0000;
   typedef enum logic [1:0] {FETCH, WAIT, DISCARD, HALTED} fetch_state_t;
endpackage

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: IF/ID pipeline register with flush-to-NOP (priority) and hold controls
module fd_pipe_reg
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        flush,
   input  logic [15:0] instr,
   input  logic [15:0] pc_inc,
   output logic [15:0] fd_instr,
   output logic [15:0] fd_pc_inc,
   output logic        fd_valid
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fd_instr  <= NOP_INSTR;
         fd_pc_inc <= RESET_PC;
         fd_valid  <= 1'b0;
      end else if (flush) begin
         fd_instr <= NOP_INSTR;
         fd_valid <= 1'b0;
      end else if (!hold) begin
         fd_instr  <= instr;
         fd_pc_inc <= pc_inc;
         fd_valid  <= 1'b1;
      end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory request FSM and IF/ID register.
// Define FETCH_ALIGN_CHECK_EN to enable the sticky misaligned-PC flag on fetch_err.
module fetch_stage
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_stall,
   input  logic        FD_NOP,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] imem_addr,
   output logic        imem_rd,
   input  logic [15:0] imem_data,
   input  logic        imem_done,
   output logic [15:0] fd_instr,
   output logic [15:0] fd_pc_inc,
   output logic        fd_valid,
   output logic        fetch_err
);
   fetch_state_t state;
   logic [15:0] pc, tgt, pc_inc;
   logic active, bad, flush, halt_hit;
   assign pc_inc    = pc + 16'd2;
   assign imem_addr = pc;
   assign imem_rd   = !rst && state != HALTED;
   assign active    = state == FETCH || state == WAIT;
`ifdef FETCH_ALIGN_CHECK_EN
   assign bad = pc[0];
   always_ff @(posedge clk or posedge rst)
      if (rst) fetch_err <= 1'b0;
      else if (active && bad) fetch_err <= 1'b1;
`else
   assign bad       = 1'b0;
   assign fetch_err = 1'b0;
`endif
   // a stall alone freezes IF/ID; every other non-delivering cycle leaves a bubble
   assign flush = redirect || FD_NOP || state == DISCARD ||
                  (!if_stall && (state == HALTED || !imem_done || bad));
   assign halt_hit = active && !redirect && !FD_NOP && !if_stall && imem_done &&
                     !bad && imem_data == HALT_INSTR;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= FETCH;
         pc    <= RESET_PC;
         tgt   <= RESET_PC;
      end else if (redirect) begin
         if (!imem_done && (state == WAIT || state == DISCARD)) begin
            tgt   <= redirect_pc;
            state <= DISCARD;
         end else begin
            pc    <= redirect_pc;
            state <= FETCH;
         end
      end else if (state == DISCARD) begin
         if (imem_done) begin
            pc    <= tgt;
            state <= FETCH;
         end
      end else if (active && (FD_NOP || !if_stall)) begin
         state <= !imem_done ? WAIT : halt_hit ? HALTED : FETCH;
         if (imem_done && !if_stall && !halt_hit) pc <= pc_inc;
      end
   fd_pipe_reg u_fd (
      .clk      (clk),
      .rst      (rst),
      .hold     (if_stall),
      .flush    (flush),
      .instr    (imem_data),
      .pc_inc   (pc_inc),
      .fd_instr (fd_instr),
      .fd_pc_inc(fd_pc_inc),
      .fd_valid (fd_valid)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + randomized fetch_stage bench; a behavioural fetch model
// fills a per-cycle expectation queue that an independent monitor drains and checks.
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst, if_stall, FD_NOP, redirect, imem_rd, imem_done, fd_valid, fetch_err;
   logic [15:0] redirect_pc, imem_addr, imem_data, fd_instr, fd_pc_inc;
   typedef struct {
      logic [15:0] addr;
      logic [15:0] instr;
      logic [15:0] pc_inc;
      logic        rd;
      logic        valid;
   } exp_t;
   exp_t q[$];
   int vectors = 0, miscompares = 0;
   logic [15:0] mem [256];
   logic [15:0] m_pc = 16'h0000, m_tgt = 16'h0000, m_instr = 16'h0800, m_inc = 16'h0000;
   bit m_valid = 0, m_wait = 0, m_pend = 0, m_halt = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk        (clk),
      .rst        (rst),
      .if_stall   (if_stall),
      .FD_NOP     (FD_NOP),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_addr  (imem_addr),
      .imem_rd    (imem_rd),
      .imem_data  (imem_data),
      .imem_done  (imem_done),
      .fd_instr   (fd_instr),
      .fd_pc_inc  (fd_pc_inc),
      .fd_valid   (fd_valid),
      .fetch_err  (fetch_err)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic bubble();
      m_instr = 16'h0800;
      m_valid = 0;
   endtask

   // Drive one cycle of inputs, advance the reference model, queue what the DUT must show after the edge.
   task automatic step(input bit r_st, input bit r, input logic [15:0] rp,
                       input bit fn, input bit st, input bit dn);
      logic [15:0] d;
      d = mem[m_pc[8:1]];
      rst = r_st; redirect = r; redirect_pc = rp; FD_NOP = fn; if_stall = st;
      imem_done = dn; imem_data = d;
      if (r_st) begin
         m_pc = 16'h0000; m_tgt = 16'h0000; m_inc = 16'h0000; bubble();
         m_wait = 0; m_pend = 0; m_halt = 0;
      end else if (r) begin
         bubble();
         if (!dn && (m_wait || m_pend)) begin
            m_pend = 1;
            m_tgt  = rp;
         end else begin
            m_pc   = rp;
            m_pend = 0;
            m_halt = 0;
         end
         m_wait = 0;
      end else if (m_pend) begin
         bubble();
         if (dn) begin
            m_pc   = m_tgt;
            m_pend = 0;
         end
      end else if (m_halt) begin
         if (fn || !st) bubble();
      end else if (fn) begin
         bubble();
         m_wait = !dn;
         if (dn && !st) m_pc = m_pc + 16'd2;
      end else if (!st) begin
         if (!dn) begin
            bubble();
            m_wait = 1;
         end else begin
            m_instr = d; m_inc = m_pc + 16'd2; m_valid = 1; m_wait = 0;
            if (d == 16'h0000) m_halt = 1;
            else m_pc = m_pc + 16'd2;
         end
      end
      q.push_back('{m_pc, m_instr, m_inc, !r_st && !m_halt, m_valid});
      @(negedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            vectors++;
            chk("imem_addr", imem_addr, e.addr);
            chk("imem_rd", 16'(imem_rd), 16'(e.rd));
            chk("fd_valid", 16'(fd_valid), 16'(e.valid));
            chk("fd_instr", fd_instr, e.instr);
            if (e.valid) chk("fd_pc_inc", fd_pc_inc, e.pc_inc);
            chk("fetch_err", 16'(fetch_err), 16'h0000);
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = (i >= 10 && $urandom_range(0, 11) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      mem[16]  = 16'h0000;
      mem[32]  = 16'h4321;
      mem[128] = 16'h5555;
      mem[255] = 16'h1234;
      step(1, 0, 16'h0, 0, 0, 0);
      step(1, 0, 16'h0, 0, 0, 1);
      repeat (3) step(0, 0, 16'h0, 0, 0, 1);
      step(0, 1, 16'h0010, 0, 0, 1);
      repeat (3) step(0, 0, 16'h0, 0, 0, 0);
      step(0, 0, 16'h0, 0, 0, 1);
      step(0, 0, 16'h0, 0, 0, 0);
      step(0, 1, 16'h0100, 0, 0, 0);
      step(0, 0, 16'h0, 0, 0, 0);
      step(0, 0, 16'h0, 0, 0, 1);
      step(0, 0, 16'h0, 0, 0, 1);
      step(0, 0, 16'h0, 1, 1, 1);
      step(0, 1, 16'h0200, 1, 1, 1);
      step(0, 0, 16'h0, 0, 1, 1);
      step(0, 0, 16'h0, 0, 0, 1);
      step(0, 1, 16'h0020, 0, 0, 0);
      step(0, 0, 16'h0, 0, 0, 1);
      repeat (3) step(0, 0, 16'h0, 0, 0, 0);
      step(0, 1, 16'h0040, 0, 0, 0);
      step(0, 0, 16'h0, 0, 0, 1);
      step(0, 1, 16'hFFFE, 0, 0, 0);
      step(0, 0, 16'h0, 0, 0, 1);
      step(0, 0, 16'h0, 0, 0, 0);
      step(1, 0, 16'h0, 0, 0, 0);
      step(0, 0, 16'h0, 0, 0, 1);
      repeat (3000)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
              16'($urandom_range(0, 65535)) & 16'hFFFE, $urandom_range(0, 9) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: if_stall  input  1  hazard unit; hold PC and IF/ID contents.
REQ-004 SHALL have port: FD_NOP  input  1  hazard unit; load NOP into IF/ID.
REQ-005 SHALL have port: redirect  input  1  taken branch/jump resolved downstream.
REQ-006 SHALL have port: redirect_pc  input  16  target address when redirect=1.
REQ-007 SHALL have ports: imem_addr  output  16; imem_rd  output  1  instruction-memory request.
REQ-008 SHALL have ports: imem_data  input  16; imem_done  input  1  read data valid this cycle.
REQ-009 SHALL have ports: fd_instr  output  16; fd_pc_inc  output  16; fd_valid  output  1  IF/ID register contents.
REQ-010 SHALL have port: fetch_err  output  1  misaligned PC flag (macro-gated, REQ-030).

Function
REQ-011 SHALL keep a 16-bit PC; imem_addr SHALL equal PC combinationally.
REQ-012 SHALL implement FSM states FETCH, WAIT, DISCARD, HALTED.
REQ-013 FETCH/WAIT/DISCARD SHALL drive imem_rd=1; HALTED SHALL drive imem_rd=0.
REQ-014 FETCH or WAIT, imem_done=1, no redirect/FD_NOP/if_stall: fd_instr<=imem_data, fd_pc_inc<=PC+2, fd_valid<=1, PC<=PC+2, state<=FETCH.
REQ-015 FETCH, imem_done=0: state<=WAIT, fd_instr<=NOP (0x0800), fd_valid<=0, PC held.
REQ-016 WAIT, imem_done=0: remain WAIT, PC held, IF/ID holds NOP bubble.
REQ-017 PC+2 SHALL wrap modulo 2^16 (0xFFFE -> 0x0000).
REQ-018 Priority SHALL be rst > redirect > FD_NOP > if_stall > normal advance.
REQ-019 redirect in FETCH or HALTED: PC<=redirect_pc, IF/ID<=NOP (valid 0), state<=FETCH, regardless of imem_done.
REQ-020 redirect in WAIT with imem_done=0: latch redirect_pc, state<=DISCARD, IF/ID<=NOP.
REQ-021 redirect in WAIT with imem_done=1: data dropped, behave as REQ-019.
REQ-022 DISCARD: imem_done=1 drops data, PC<=latched target, state<=FETCH; a newer redirect SHALL overwrite the latched target.
REQ-023 FD_NOP=1 (no redirect): IF/ID<=NOP, fd_valid<=0; PC advances on imem_done unless if_stall=1.
REQ-024 if_stall=1 alone: PC, IF/ID, state held; a completing read is discarded and reissued next cycle.
REQ-025 Fetched HALT (0x0000) latched into IF/ID: state<=HALTED, PC held at halt address; IF/ID<=NOP next cycle.
REQ-026 HALTED: exit only on redirect (halt in branch shadow) or rst.

Reset
REQ-027 rst=1 SHALL asynchronously force PC=0x0000, state=FETCH, fd_instr=0x0800, fd_pc_inc=0x0000, fd_valid=0, latched target=0, fetch_err=0.
REQ-028 imem_rd SHALL be 0 while rst=1; first request issued cycle after deassertion.
REQ-029 rst mid-WAIT SHALL abandon the outstanding read; late imem_done after reset is treated as a fresh FETCH response.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN defined: fetch_err<=1 (sticky until rst) when PC[0]=1 at request; IF/ID loads NOP instead of data.
REQ-031 Macro undefined: fetch_err tied 0, PC[0] ignored, no check logic.

Structure
REQ-032 Shared package pipe_pkg SHALL hold NOP_INSTR (0x0800), HALT_INSTR (0x0000), RESET_PC (0x0000), fetch FSM state enum.
REQ-033 One sub-module fd_pipe_reg SHALL hold fd_instr/fd_pc_inc/fd_valid with hold (if_stall) and flush (NOP) controls.

Verification
REQ-034 Hits every cycle from reset -> fd_pc_inc sequence 0x0002, 0x0004, 0x0006; fd_valid=1 from cycle 2.
REQ-035 imem_done low 3 cycles at PC=0x0010 -> 3 bubbles (fd_instr 0x0800, valid 0), then instruction at 0x0010, PC 0x0012.
REQ-036 redirect to 0x0100 during WAIT, imem_done 2 cycles later -> returned data dropped, next imem_addr=0x0100, no valid instruction from old PC.
REQ-037 if_stall and FD_NOP both high with imem_done -> PC held, IF/ID=NOP; redirect same cycle -> PC=redirect_pc.
REQ-038 HALT at 0x0020 -> imem_rd=0, PC=0x0020 held; redirect to 0x0040 -> FETCH resumes at 0x0040; PC 0xFFFE wraps to 0x0000.
